// File: rtl/ufm_pkg.sv
// Shared constants for the UFM serial responder: default widths, FSM encoding
// and the fill value driven onto the data register when no word is available.
package ufm_pkg;

  localparam int unsigned AW_DEFAULT = 23;
  localparam int unsigned DW_DEFAULT = 32;

  localparam logic FILL_BIT = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

endpackage

// File: rtl/ufm_edge_sync.sv
// Multi-flop synchronizer for an asynchronous serial clock, followed by a
// registered rising-edge detector producing a one-cycle pulse in the clk domain.
module ufm_edge_sync #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC-1:0] sr;
  logic            prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sr   <= {sr[SYNC-2:0], d};
      prev <= sr[SYNC-1];
      rise <= sr[SYNC-1] & ~prev;
    end
  end

endmodule

// File: rtl/ufm_serial_responder.sv
// Serial address/data register front end that prefetches one memory word per
// address update and serves it through a shift register on drclk.
module ufm_serial_responder
  import ufm_pkg::*;
#(
  parameter int unsigned AW   = AW_DEFAULT,
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arclk,
  input  logic          arshft,
  input  logic          ardin,
  input  logic          drclk,
  input  logic          drshft,
  input  logic          drdin,
  output logic          drout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          busy,
  output logic          err
);

  logic ar_rise;
  logic dr_rise;

  ufm_edge_sync #(.SYNC(SYNC)) u_arclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (arclk),
    .rise (ar_rise)
  );

  ufm_edge_sync #(.SYNC(SYNC)) u_drclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (drclk),
    .rise (dr_rise)
  );

  // Data pins only need the synchronizer chain; no edge detection.
  logic [SYNC-1:0] arshft_sr, ardin_sr, drshft_sr, drdin_sr;
  logic            arshft_s, ardin_s, drshft_s, drdin_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      arshft_sr <= '0;
      ardin_sr  <= '0;
      drshft_sr <= '0;
      drdin_sr  <= '0;
    end else begin
      arshft_sr <= {arshft_sr[SYNC-2:0], arshft};
      ardin_sr  <= {ardin_sr[SYNC-2:0],  ardin};
      drshft_sr <= {drshft_sr[SYNC-2:0], drshft};
      drdin_sr  <= {drdin_sr[SYNC-2:0],  drdin};
    end
  end

  assign arshft_s = arshft_sr[SYNC-1];
  assign ardin_s  = ardin_sr[SYNC-1];
  assign drshft_s = drshft_sr[SYNC-1];
  assign drdin_s  = drdin_sr[SYNC-1];

  logic [AW-1:0] addr;
  logic [DW-1:0] dr;
  logic [DW-1:0] pbuf;
  logic [1:0]    state;
  logic [1:0]    outst;
  logic [1:0]    outst_nxt;
  logic          take_valid;

  // Reads issued but not yet answered. Only the newest read may complete a
  // fetch, so a response is taken only when it is the single one outstanding
  // and no newer read is being issued in the same cycle.
  always_comb begin
    outst_nxt = outst;
    if (mem_rd && !(mem_valid && outst != 2'd0)) begin
      if (outst != 2'd3) outst_nxt = outst + 2'd1;
    end else if (!mem_rd && mem_valid && outst != 2'd0) begin
      outst_nxt = outst - 2'd1;
    end
  end

  assign take_valid = mem_valid && (state == ST_FETCH) && !mem_rd && (outst == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      dr     <= {DW{FILL_BIT}};
      pbuf   <= '0;
      state  <= ST_IDLE;
      outst  <= 2'd0;
      mem_rd <= 1'b0;
      err    <= 1'b0;
    end else begin
      outst <= outst_nxt;

      if (ar_rise) begin
        addr   <= arshft_s ? {addr[AW-2:0], ardin_s} : addr + AW'(1);
        state  <= ST_FETCH;
        mem_rd <= 1'b1;
      end else begin
        mem_rd <= 1'b0;
        if (take_valid) begin
          pbuf  <= mem_rdata;
          state <= ST_READY;
        end
      end

      // Loads look at the registered state, i.e. the state before any
      // address update taking effect on this same edge.
      if (dr_rise) begin
        if (!drshft_s) begin
          if (state == ST_READY) begin
            dr <= pbuf;
          end else begin
            dr  <= {DW{FILL_BIT}};
            err <= 1'b1;
          end
        end else begin
          dr <= {dr[DW-2:0], drdin_s};
        end
      end
    end
  end

  assign mem_addr = addr;
  assign busy     = (state == ST_FETCH);
  assign drout    = dr[DW-1];

endmodule

// File: tb/tb_ufm_serial_responder.sv
// Directed bench for ufm_serial_responder with a small in-order memory responder.
module tb_ufm_serial_responder;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arclk = 1'b0, arshft = 1'b0, ardin = 1'b0;
  logic          drclk = 1'b0, drshft = 1'b0, drdin = 1'b0;
  logic          drout;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          busy;
  logic          err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ufm_serial_responder #(.AW(AW), .DW(DW), .SYNC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .arclk     (arclk),
    .arshft    (arshft),
    .ardin     (ardin),
    .drclk     (drclk),
    .drshft    (drshft),
    .drdin     (drdin),
    .drout     (drout),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .busy      (busy),
    .err       (err)
  );

  // In-order memory: every mem_rd is answered after rsp_lat cycles with the
  // rsp_data value current when the read was seen.
  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rsp_t;

  rsp_t          rq[$];
  int unsigned   cyc = 0;
  int unsigned   rsp_lat = 2;
  logic [31:0]   rsp_data = '0;
  int unsigned   rd_cnt = 0;
  logic [AW-1:0] last_rd_addr = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    mem_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_valid = 1'b1;
      mem_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    if (mem_rd) begin
      rd_cnt = rd_cnt + 1;
      last_rd_addr = mem_addr;
      rq.push_back('{due: cyc + rsp_lat, data: rsp_data});
    end
  end

  // One 80 ns serial period; starts and ends on a falling clk edge.
  task automatic serial_edge(input logic a_en, input logic a_sh, input logic a_d,
                             input logic d_en, input logic d_sh, input logic d_d);
    arshft = a_sh; ardin = a_d; drshft = d_sh; drdin = d_d;
    #30;
    if (a_en) arclk = 1'b1;
    if (d_en) drclk = 1'b1;
    #40;
    arclk = 1'b0; drclk = 1'b0;
    #10;
  endtask

  task automatic ar_shift_word(input logic [AW-1:0] w, input int nbits,
                               input int unsigned lat_last, input logic [31:0] data_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == 0) begin rsp_lat = lat_last; rsp_data = data_last; end
      else begin rsp_lat = 2; rsp_data = '0; end
      serial_edge(1'b1, 1'b1, w[i], 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_idle(input string name);
    int unsigned k = 0;
    while ((busy || rq.size() != 0) && k < 80) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, k);
    end
  endtask

  // Load (optionally with a simultaneous arclk increment), then 32 shifts;
  // returns the 33 drout samples, first sample in bit 32.
  task automatic dr_read(input logic ar_too, input logic din_one, output logic [32:0] bits);
    serial_edge(ar_too, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bits[32] = drout;
    for (int i = 1; i <= 32; i++) begin
      serial_edge(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, din_one ? 1'b1 : ~i[0]);
      bits[32-i] = drout;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_addr !== '0)  begin n_fail++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++; if (drout !== 1'b1)   begin n_fail++; $display("FAIL reset_drout: got %b required 1", drout); end
    n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_tests++; if (mem_rd !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_rd: got %b required 0", mem_rd); end
  endtask

  task automatic test_addr_shift();
    int unsigned rd0 = rd_cnt;
    ar_shift_word(23'h12345, 23, 12, 32'hDEADBEEF);
    n_tests++; if (mem_addr !== 23'h12345) begin n_fail++; $display("FAIL shift_addr: got %h required 12345", mem_addr); end
    n_tests++; if (last_rd_addr !== 23'h12345) begin n_fail++; $display("FAIL shift_rd_addr: got %h required 12345", last_rd_addr); end
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL shift_busy: got %b required 1", busy); end
    wait_idle("shift_fetch_done");
    n_tests++; if (rd_cnt - rd0 != 23) begin n_fail++; $display("FAIL shift_rd_count: got %0d required 23", rd_cnt - rd0); end
  endtask

  task automatic test_data_shift();
    logic [32:0] bits;
    dr_read(1'b0, 1'b0, bits);
    n_tests++; if (bits !== {32'hDEADBEEF, 1'b0}) begin n_fail++; $display("FAIL data_shift: got %h required %h", bits, {32'hDEADBEEF, 1'b0}); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL data_err: got %b required 0", err); end
  endtask

  task automatic test_stale_restart();
    logic [32:0] bits;
    rsp_lat = 12; rsp_data = 32'h11111111;
    serial_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rsp_lat = 8;  rsp_data = 32'h22222222;
    serial_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stale_busy: got %b required 1", busy); end
    wait_idle("stale_fetch_done");
    dr_read(1'b0, 1'b0, bits);
    n_tests++; if (bits !== {32'h22222222, 1'b0}) begin n_fail++; $display("FAIL stale_word: got %h required %h", bits, {32'h22222222, 1'b0}); end
  endtask

  task automatic test_simultaneous();
    logic [32:0] bits;
    int unsigned rd0 = rd_cnt;
    rsp_lat = 3; rsp_data = 32'h33333333;
    dr_read(1'b1, 1'b0, bits);
    n_tests++; if (bits !== {32'h22222222, 1'b0}) begin n_fail++; $display("FAIL simul_word: got %h required %h", bits, {32'h22222222, 1'b0}); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL simul_err: got %b required 0", err); end
    n_tests++; if (mem_addr !== 23'h12348) begin n_fail++; $display("FAIL simul_addr: got %h required 12348", mem_addr); end
    n_tests++; if (rd_cnt - rd0 != 1) begin n_fail++; $display("FAIL simul_rd_count: got %0d required 1", rd_cnt - rd0); end
    wait_idle("simul_fetch_done");
  endtask

  task automatic test_wrap();
    int unsigned rd0;
    ar_shift_word(23'h7FFFFF, 23, 2, 32'h0);
    n_tests++; if (mem_addr !== 23'h7FFFFF) begin n_fail++; $display("FAIL wrap_max: got %h required 7fffff", mem_addr); end
    wait_idle("wrap_max_done");
    rd0 = rd_cnt;
    rsp_lat = 2; rsp_data = 32'h0;
    serial_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL wrap_addr: got %h required 0", mem_addr); end
    n_tests++; if (rd_cnt - rd0 != 1) begin n_fail++; $display("FAIL wrap_rd_count: got %0d required 1", rd_cnt - rd0); end
    n_tests++; if (last_rd_addr !== '0) begin n_fail++; $display("FAIL wrap_rd_addr: got %h required 0", last_rd_addr); end
    wait_idle("wrap_done");
  endtask

  task automatic test_busy_load();
    logic [32:0] bits;
    rsp_lat = 20; rsp_data = 32'h44444444;
    serial_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busyload_busy: got %b required 1", busy); end
    dr_read(1'b0, 1'b1, bits);
    n_tests++; if (bits !== 33'h1_FFFF_FFFF) begin n_fail++; $display("FAIL busyload_bits: got %h required 1ffffffff", bits); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL busyload_err: got %b required 1", err); end
    wait_idle("busyload_done");
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL busyload_err_sticky: got %b required 1", err); end
  endtask

  task automatic test_reset_midshift();
    logic [32:0] bits;
    ar_shift_word(23'h2A5, 10, 15, 32'h55555555);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr: got %h required 0", mem_addr); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    n_tests++; if (drout !== 1'b1)  begin n_fail++; $display("FAIL rstmid_drout: got %b required 1", drout); end
    n_tests++; if (err !== 1'b0)    begin n_fail++; $display("FAIL rstmid_err: got %b required 0", err); end
    repeat (20) @(negedge clk);
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_stale_valid: busy got %b required 0", busy); end
    ar_shift_word(23'h5A5A5, 23, 4, 32'h66666666);
    n_tests++; if (mem_addr !== 23'h5A5A5) begin n_fail++; $display("FAIL rstmid_reshift_addr: got %h required 5a5a5", mem_addr); end
    wait_idle("rstmid_fetch_done");
    dr_read(1'b0, 1'b0, bits);
    n_tests++; if (bits !== {32'h66666666, 1'b0}) begin n_fail++; $display("FAIL rstmid_word: got %h required %h", bits, {32'h66666666, 1'b0}); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_after: got %b required 0", err); end
  endtask

  initial begin
    test_reset();
    test_addr_shift();
    test_data_shift();
    test_stale_restart();
    test_simultaneous();
    test_wrap();
    test_busy_load();
    test_reset_midshift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
